// File: rtl/softmax_seq_ctrl_pkg.sv
// Shared constants and state encoding for the softmax layer sequencer.
package softmax_seq_ctrl_pkg;

    localparam int unsigned SM_ROWS   = 32;
    localparam int unsigned SM_N      = 8;
    localparam int unsigned SM_TILE_W = 2;
    localparam int unsigned SM_TMO    = 255;
    localparam int unsigned SM_TMO_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_tmo_cnt.sv
// Loadable down-counter used as a watchdog by the layer sequencers.
// Priority is clear, then load, then enable; the count saturates at zero
// and expired is high whenever the count is zero.
module seq_tmo_cnt
    import softmax_seq_ctrl_pkg::*;
#(
    parameter int unsigned W = SM_TMO_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // Count register: clear / load / saturating decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer for the N-row softmax layer: walks ROWS rows in tiles of N,
// fetching operands, running the layer, and handing each result downstream.
// Every output is a register fed from the next-state decode, so outputs line
// up with the state they describe and no input reaches an output directly.
module softmax_seq_ctrl
    import softmax_seq_ctrl_pkg::*;
#(
    parameter int unsigned ROWS   = SM_ROWS,
    parameter int unsigned N      = SM_N,
    parameter int unsigned TILE_W = SM_TILE_W,
    parameter int unsigned TMO    = SM_TMO,
    parameter int unsigned TMO_W  = SM_TMO_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en,
    output logic [TILE_W-1:0] rd_tile,
    input  logic              rd_valid,
    output logic              load_d_num,
    output logic              run,
    input  logic              sm_valid,
    output logic              wr_en,
    output logic [TILE_W-1:0] wr_tile,
    input  logic              wr_ready
);

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(ROWS / N - 1);
    // The watchdog expires on the TMO-th RUN cycle, so it is loaded with TMO-1.
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TMO - 1);

    state_t            state, state_next;
    logic [TILE_W-1:0] tile, tile_next;
    logic              run_first;
    logic              tmo_expired;

    logic              busy_d, done_d, error_d, rd_en_d, load_d, run_d, wr_en_d;
    logic [TILE_W-1:0] rd_tile_d, wr_tile_d;

    seq_tmo_cnt #(.W(TMO_W)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ST_IDLE),
        .load     (state == ST_LOAD),
        .load_val (TMO_LOAD),
        .en       (state == ST_RUN),
        .expired  (tmo_expired)
    );

    // Next-state, tile and output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        tile_next  = tile;
        error_d    = error;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_tile_d  = '0;
        load_d     = 1'b0;
        run_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_tile_d  = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    tile_next  = '0;
                    error_d    = 1'b0;
                end
            end
            // rd_valid seen while rd_en is out is ignored by leaving FETCH unconditionally.
            ST_FETCH:   state_next = ST_WAIT_RD;
            ST_WAIT_RD: if (rd_valid) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_RUN;
            ST_RUN: begin
                // A valid left over from the previous pass is ignored in the first
                // RUN cycle; a fresh valid beats a simultaneous timeout.
                if (sm_valid && !run_first) begin
                    state_next = ST_DRAIN;
                end else if (tmo_expired) begin
                    state_next = ST_IDLE;
                    error_d    = 1'b1;
                end
            end
            ST_DRAIN:   state_next = ST_WRITE;
            ST_WRITE:   if (wr_ready) state_next = ST_NEXT;
            ST_NEXT: begin
                if (tile == LAST_TILE) begin
                    state_next = ST_DONE;
                end else begin
                    tile_next  = tile + 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase

        case (state_next)
            ST_FETCH: begin
                rd_en_d   = 1'b1;
                rd_tile_d = tile_next;
            end
            ST_LOAD: begin
                load_d = 1'b1;
                run_d  = 1'b1;
            end
            ST_RUN:   run_d = 1'b1;
            ST_WRITE: begin
                wr_en_d   = 1'b1;
                wr_tile_d = tile_next;
            end
            ST_DONE:  done_d = 1'b1;
            default:  ;
        endcase

        busy_d = (state_next != ST_IDLE) && (state_next != ST_DONE);
    end

    // State, tile counter, stale-valid guard and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset clears every register here, so an abort mid-sequence drops
        // all outputs at once and never produces a done pulse.
        if (!rst_n) begin
            state      <= ST_IDLE;
            tile       <= '0;
            run_first  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rd_en      <= 1'b0;
            rd_tile    <= '0;
            load_d_num <= 1'b0;
            run        <= 1'b0;
            wr_en      <= 1'b0;
            wr_tile    <= '0;
        end else begin
            state      <= state_next;
            tile       <= tile_next;
            run_first  <= (state == ST_LOAD);
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            rd_en      <= rd_en_d;
            rd_tile    <= rd_tile_d;
            load_d_num <= load_d;
            run        <= run_d;
            wr_en      <= wr_en_d;
            wr_tile    <= wr_tile_d;
        end
    end

endmodule
